// File: rtl/tqv_spi_reg_bridge.sv
// SPI-slave (mode 0) to peripheral-register bridge with configurable address/data widths.
// Optional burst mode (auto-incrementing address) is enabled by defining TQV_SPI_BURST_EN.
module tqv_spi_reg_bridge #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              data_write,
  output logic              data_read,
  input  logic [DATA_W-1:0] data_out
);

  localparam int CNT_W = 6;

`ifdef TQV_SPI_BURST_EN
  localparam logic BURST_EN = 1'b1;
`else
  localparam logic BURST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sclk_prev_r;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   sclk_rise_s;
  logic                   sclk_fall_s;

  logic [CNT_W-1:0]  bit_cnt_r;
  logic [ADDR_W-1:0] cmd_sh_r;
  logic [DATA_W-1:0] rx_sh_r;
  logic [DATA_W-1:0] tx_sh_r;
  logic              rw_r;
  logic              rd_go_r;
  logic              cap_r;
  logic              inc_r;

  logic [ADDR_W:0]   cmd_word_s;
  logic [DATA_W-1:0] rx_word_s;
  logic              cmd_last_s;
  logic              data_last_s;
  logic              cmd_done_s;
  logic              word_done_s;

  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_s & sclk_prev_r;

  // Input synchronisers; chip select resets to the deselected level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_r   <= '1;
      sclk_sync_r <= '0;
      mosi_sync_r <= '0;
      sclk_prev_r <= 1'b0;
    end else begin
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_r <= sclk_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; a deselected chip select aborts from any state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!cs_s) state_next_s = ST_CMD;
        else       state_next_s = ST_IDLE;
      end
      ST_CMD: begin
        if (cs_s)            state_next_s = ST_IDLE;
        else if (cmd_done_s) state_next_s = ST_DATA;
        else                 state_next_s = ST_CMD;
      end
      ST_DATA: begin
        if (cs_s) begin
          state_next_s = ST_IDLE;
        end else if (word_done_s) begin
          if (BURST_EN) state_next_s = ST_DATA;
          else          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_DONE: begin
        if (cs_s) state_next_s = ST_IDLE;
        else      state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output decode: frame-boundary events for the datapath.
  always_comb begin
    cmd_word_s  = {cmd_sh_r, mosi_s};
    rx_word_s   = {rx_sh_r[DATA_W-2:0], mosi_s};
    cmd_last_s  = (bit_cnt_r == CNT_W'(ADDR_W));
    data_last_s = (bit_cnt_r == CNT_W'(DATA_W - 1));
    cmd_done_s  = (state_r == ST_CMD) && !cs_s && sclk_rise_s && cmd_last_s;
    word_done_s = (state_r == ST_DATA) && !cs_s && sclk_rise_s && data_last_s;
  end

  // Receive path, address/data registers and read/write strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r  <= '0;
      cmd_sh_r   <= '0;
      rx_sh_r    <= '0;
      rw_r       <= 1'b0;
      rd_go_r    <= 1'b0;
      cap_r      <= 1'b0;
      inc_r      <= 1'b0;
      address    <= '0;
      data_in    <= '0;
      data_write <= 1'b0;
      data_read  <= 1'b0;
    end else begin
      data_write <= 1'b0;
      data_read  <= rd_go_r && !cs_s;
      cap_r      <= data_read;
      rd_go_r    <= 1'b0;
      inc_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r <= '0;
        end
        ST_CMD: begin
          if (sclk_rise_s && !cs_s) begin
            cmd_sh_r <= cmd_word_s[ADDR_W-1:0];
            if (cmd_last_s) begin
              bit_cnt_r <= '0;
              address   <= cmd_word_s[ADDR_W-1:0];
              rw_r      <= cmd_word_s[ADDR_W];
              rd_go_r   <= ~cmd_word_s[ADDR_W];
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise_s && !cs_s) begin
            rx_sh_r <= rx_word_s;
            if (data_last_s) begin
              bit_cnt_r <= '0;
              inc_r     <= BURST_EN;
              if (rw_r) begin
                data_in    <= rx_word_s;
                data_write <= 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
      // Increment one clk after the word so the write strobe still sees the old address.
      if (inc_r && !cs_s) begin
        address <= address + ADDR_W'(1);
        rd_go_r <= ~rw_r;
      end
    end
  end

  // Transmit path: captured read word shifted out MSB first on falling spi_clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh_r  <= '0;
      spi_miso <= 1'b0;
    end else begin
      if (cap_r) begin
        tx_sh_r <= data_out;
      end else if ((state_r == ST_DATA) && !rw_r && sclk_fall_s) begin
        tx_sh_r <= {tx_sh_r[DATA_W-2:0], 1'b0};
      end
      if ((state_r != ST_DATA) || rw_r || cs_s) begin
        spi_miso <= 1'b0;
      end else if (sclk_fall_s) begin
        spi_miso <= tx_sh_r[DATA_W-1];
      end
    end
  end

endmodule

// File: tb/tb_tqv_spi_reg_bridge.sv
// Scoreboard bench for tqv_spi_reg_bridge: an 4/8 instance and an 8/32 instance share spi_clk/mosi.
module tb_tqv_spi_reg_bridge;

  localparam int HALF = 8;

  logic        clk;
  logic        rst_n;
  logic        cs_a, cs_b, sclk, mosi;
  logic        miso_a, miso_b;
  logic [3:0]  address_a;
  logic [7:0]  data_in_a, data_out_a;
  logic        data_write_a, data_read_a;
  logic [7:0]  address_b;
  logic [31:0] data_in_b, data_out_b;
  logic        data_write_b, data_read_b;

  int checks   = 0;
  int failures = 0;
  int wr_cnt_a = 0;
  int rd_cnt_a = 0;
  int rd_cnt_b = 0;
  logic        sel_b;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [31:0] rq_a[$];
  logic [31:0] rq_b[$];
  logic [31:0] ea, ed, er_a, er_b;
  logic [63:0] rx;

  tqv_spi_reg_bridge #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(cs_a), .spi_clk(sclk), .spi_mosi(mosi),
    .spi_miso(miso_a), .address(address_a), .data_in(data_in_a),
    .data_write(data_write_a), .data_read(data_read_a), .data_out(data_out_a)
  );

  tqv_spi_reg_bridge #(.ADDR_W(8), .DATA_W(32), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(cs_b), .spi_clk(sclk), .spi_mosi(mosi),
    .spi_miso(miso_b), .address(address_b), .data_in(data_in_b),
    .data_write(data_write_b), .data_read(data_read_b), .data_out(data_out_b)
  );

  // Peripheral register models.
  assign data_out_a = (address_a == 4'h5) ? 8'h3C : {4'hA, address_a};
  assign data_out_b = (address_b == 8'hFF) ? 32'hDEADBEEF : 32'h0000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: pops the scoreboard on every data_write/data_read.
  always @(negedge clk) begin
    if (data_write_a) begin
      wr_cnt_a++;
      check("rw_exclusive_a", {63'd0, data_read_a}, 64'd0);
      if (wq_addr.size() == 0) begin
        check("unexpected_write_a", 64'(wq_addr.size()), 64'd1);
      end else begin
        ea = wq_addr.pop_front();
        ed = wq_data.pop_front();
        check("write_addr_a", 64'(address_a), 64'(ea));
        check("write_data_a", 64'(data_in_a), 64'(ed));
      end
    end
    if (data_read_a) begin
      rd_cnt_a++;
      if (rq_a.size() == 0) begin
        check("unexpected_read_a", 64'(rq_a.size()), 64'd1);
      end else begin
        er_a = rq_a.pop_front();
        check("read_addr_a", 64'(address_a), 64'(er_a));
      end
    end
    if (data_read_b) begin
      rd_cnt_b++;
      if (rq_b.size() == 0) begin
        check("unexpected_read_b", 64'(rq_b.size()), 64'd1);
      end else begin
        er_b = rq_b.pop_front();
        check("read_addr_b", 64'(address_b), 64'(er_b));
      end
    end
    if (data_write_b) begin
      check("unexpected_write_b", {63'd0, data_write_b}, 64'd0);
    end
  end

  task automatic spi_bit(input logic b, output logic s);
    mosi = b;
    repeat (HALF) @(posedge clk);
    #1;
    s = sel_b ? miso_b : miso_a;
    sclk = 1'b1;
    repeat (HALF) @(posedge clk);
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic use_b, input int nbits, input logic [63:0] tx,
                      output logic [63:0] rxv);
    logic s;
    sel_b = use_b;
    if (use_b) cs_b = 1'b0;
    else       cs_a = 1'b0;
    repeat (HALF) @(posedge clk);
    rxv = 64'd0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bit(tx[i], s);
      rxv = {rxv[62:0], s};
    end
    repeat (HALF) @(posedge clk);
    cs_a = 1'b1;
    cs_b = 1'b1;
    repeat (4 * HALF) @(posedge clk);
  endtask

  initial begin
    logic s;
    rst_n = 1'b0;
    cs_a  = 1'b1;
    cs_b  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    sel_b = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_address_a", 64'(address_a), 64'd0);
    check("reset_data_in_a", 64'(data_in_a), 64'd0);
    check("reset_strobes_a", 64'({data_write_a, data_read_a, miso_a}), 64'd0);
    check("reset_address_b", 64'(address_b), 64'd0);
    check("reset_data_in_b", 64'(data_in_b), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 1: single write 0x3 <- 0xA5
    wq_addr.push_back(32'h3); wq_data.push_back(32'hA5);
    xfer(1'b0, 13, 64'({1'b1, 4'h3, 8'hA5}), rx);
    check("t1_write_count", 64'(wr_cnt_a), 64'd1);
    check("t1_queue_empty", 64'(wq_addr.size()), 64'd0);

    // 2: read address 5 -> MISO 0x3C
    rq_a.push_back(32'h5);
`ifdef TQV_SPI_BURST_EN
    rq_a.push_back(32'h6);
`endif
    xfer(1'b0, 13, 64'({1'b0, 4'h5, 8'h00}), rx);
    check("t2_miso_word", 64'(rx[7:0]), 64'h3C);
    check("t2_read_queue_empty", 64'(rq_a.size()), 64'd0);
    check("t2_write_count", 64'(wr_cnt_a), 64'd1);

    // 3: aborted write after 4 data bits, then a clean frame
    xfer(1'b0, 9, 64'({1'b1, 4'h2, 4'hF}), rx);
    check("t3_no_write", 64'(wr_cnt_a), 64'd1);
    check("t3_address_held", 64'(address_a), 64'h2);
    check("t3_data_in_held", 64'(data_in_a), 64'hA5);
    wq_addr.push_back(32'h7); wq_data.push_back(32'h5A);
    xfer(1'b0, 13, 64'({1'b1, 4'h7, 8'h5A}), rx);
    check("t3_recovery_count", 64'(wr_cnt_a), 64'd2);
    check("t3_recovery_data", 64'(data_in_a), 64'h5A);

    // 4: three words from address 0xE
    wq_addr.push_back(32'hE); wq_data.push_back(32'h11);
`ifdef TQV_SPI_BURST_EN
    wq_addr.push_back(32'hF); wq_data.push_back(32'h22);
    wq_addr.push_back(32'h0); wq_data.push_back(32'h33);
`endif
    xfer(1'b0, 29, 64'({1'b1, 4'hE, 8'h11, 8'h22, 8'h33}), rx);
    check("t4_queue_empty", 64'(wq_addr.size()), 64'd0);
`ifdef TQV_SPI_BURST_EN
    check("t4_write_count", 64'(wr_cnt_a), 64'd5);
    check("t4_address_wrapped", 64'(address_a), 64'h1);
`else
    check("t4_write_count", 64'(wr_cnt_a), 64'd3);
    check("t4_address_fixed", 64'(address_a), 64'hE);
`endif
    check("t4_miso_quiet", 64'(rx), 64'd0);

    // 5: 32-bit read of address 0xFF
    rq_b.push_back(32'hFF);
`ifdef TQV_SPI_BURST_EN
    rq_b.push_back(32'h00);
`endif
    xfer(1'b1, 41, 64'({1'b0, 8'hFF, 32'h0}), rx);
    check("t5_miso_word", 64'(rx[31:0]), 64'hDEADBEEF);
    check("t5_read_queue_empty", 64'(rq_b.size()), 64'd0);
    check("t5_address_b", 64'(address_b), 64'hFF);

    // 6: reset in the middle of the command phase
    sel_b = 1'b0;
    cs_a  = 1'b0;
    repeat (HALF) @(posedge clk);
    spi_bit(1'b1, s);
    spi_bit(1'b0, s);
    spi_bit(1'b1, s);
    rst_n = 1'b0;
    #1;
    check("t6_reset_address", 64'(address_a), 64'd0);
    check("t6_reset_data_in", 64'(data_in_a), 64'd0);
    check("t6_reset_strobes", 64'({data_write_a, data_read_a, miso_a}), 64'd0);
    repeat (3) @(posedge clk);
    cs_a = 1'b1;
    repeat (HALF) @(posedge clk);
    rst_n = 1'b1;
    repeat (HALF) @(posedge clk);
    wq_addr.push_back(32'h9); wq_data.push_back(32'hC3);
    xfer(1'b0, 13, 64'({1'b1, 4'h9, 8'hC3}), rx);
    check("t6_queue_empty", 64'(wq_addr.size()), 64'd0);
`ifdef TQV_SPI_BURST_EN
    check("t6_write_count", 64'(wr_cnt_a), 64'd6);
`else
    check("t6_write_count", 64'(wr_cnt_a), 64'd4);
`endif
    check("t6_address", 64'(address_a), 64'h9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
